axi4_lite_master: RTL and testbench

AXI4-Lite initiator that converts single load/store requests from the RV32IM core's memory port into AXI4-Lite transactions toward the interconnect and peripheral slaves. It issues one transaction at a time, write or read. It drives the AW/W/B and AR/R channels per AXI4-Lite handshake rules and returns read data and response status to the requester.

---
 rtl/axi4_lite_master.sv | 203 ++++++++++++++++++++
 tb/tb_axi4_lite_master.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_master.sv
// AXI4-Lite initiator: turns single load/store requests from the core's
// memory port into one AXI4-Lite transaction at a time. Write requests
// drive AW/W/B, read requests drive AR/R. Completion comes back as a
// one-cycle resp_valid pulse carrying the error flag and, for reads, the data.
module axi4_lite_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  // requester side
  input  logic                  req_write,
  input  logic                  req_read,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [3:0]            req_wstrb,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,

  // write address channel
  output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,

  // write data channel
  output logic [DATA_WIDTH-1:0] M_AXI_WDATA,
  output logic [3:0]            M_AXI_WSTRB,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,

  // write response channel
  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY,

  // read address channel
  output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,

  // read data channel
  input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY
);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA
  } state_e;

  state_e                state_q, state_d;

  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic                  awvalid_q, awvalid_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  wvalid_q, wvalid_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic                  arvalid_q, arvalid_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic                  resp_err_q, resp_err_d;

  // AW and W may finish in either order; a channel counts as done once its
  // valid has already dropped or its handshake happens on the coming edge.
  logic                  aw_done;
  logic                  w_done;

  // Only bit 1 of a response (SLVERR/DECERR) matters to the requester.
  logic                  unused_resp_lsb;
  assign unused_resp_lsb = M_AXI_BRESP[0] ^ M_AXI_RRESP[0];

  // State register and all registered outputs; reset aborts any transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      awaddr_q     <= '0;
      awvalid_q    <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      wvalid_q     <= 1'b0;
      araddr_q     <= '0;
      arvalid_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      awaddr_q     <= awaddr_d;
      awvalid_q    <= awvalid_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      wvalid_q     <= wvalid_d;
      araddr_q     <= araddr_d;
      arvalid_q    <= arvalid_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Next-state and next-output logic; payloads hold unless a new request lands.
  always_comb begin
    state_d      = state_q;
    awaddr_d     = awaddr_q;
    awvalid_d    = awvalid_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    wvalid_d     = wvalid_q;
    araddr_d     = araddr_q;
    arvalid_d    = arvalid_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    aw_done      = 1'b0;
    w_done       = 1'b0;

    case (state_q)
      IDLE: begin
        // A store wins over a load; the load waits for req_ready again.
        if (req_write) begin
          awaddr_d  = req_addr;
          wdata_d   = req_wdata;
          wstrb_d   = req_wstrb;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = WR_ADDR_DATA;
        end else if (req_read) begin
          araddr_d  = req_addr;
          arvalid_d = 1'b1;
          state_d   = RD_ADDR;
        end
      end

      WR_ADDR_DATA: begin
        aw_done = !awvalid_q || M_AXI_AWREADY;
        w_done  = !wvalid_q  || M_AXI_WREADY;
        if (awvalid_q && M_AXI_AWREADY) begin
          awvalid_d = 1'b0;
        end
        if (wvalid_q && M_AXI_WREADY) begin
          wvalid_d = 1'b0;
        end
        if (aw_done && w_done) begin
          state_d = WR_RESP;
        end
      end

      WR_RESP: begin
        if (M_AXI_BVALID) begin
          resp_err_d   = M_AXI_BRESP[1];
          resp_valid_d = 1'b1;
          state_d      = IDLE;
        end
      end

      RD_ADDR: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = RD_DATA;
        end
      end

      RD_DATA: begin
        if (M_AXI_RVALID) begin
          resp_rdata_d = M_AXI_RDATA;
          resp_err_d   = M_AXI_RRESP[1];
          resp_valid_d = 1'b1;
          state_d      = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Ready strobes toward requester and slaves come straight from the state.
  assign req_ready     = (state_q == IDLE);
  assign M_AXI_BREADY  = (state_q == WR_RESP);
  assign M_AXI_RREADY  = (state_q == RD_DATA);

  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign resp_err      = resp_err_q;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Bench for axi4_lite_master: directed scenarios plus randomized traffic
// against a cycle-count reference model derived from the handshake rules.
module tb_axi4_lite_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_write, req_read;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready, arvalid, arready, rvalid, rready;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] last_rdata;

  always #5 clk = ~clk;

  axi4_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_write(req_write), .req_read(req_read), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid),
    .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // {req_ready, awvalid, wvalid, bready, arvalid, rready, resp_valid}
  function automatic logic [6:0] ctl();
    return {req_ready, awvalid, wvalid, bready, arvalid, rready, resp_valid};
  endfunction

  task automatic clear_slave();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0; rresp = 2'b00; rdata = '0;
  endtask

  // Called just after a falling-edge sample with the DUT idle. Cycle c is the
  // cycle following accept edge N + c - 1. The slave accepts AW in cycle
  // 1+aw_w, W in cycle 1+w_w, and answers B b_w cycles after both are done.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_w, input int w_w, input int b_w,
                          input logic [1:0] br, input bit hold_read);
    int         hs;
    int         last;
    logic [6:0] exp;
    hs   = 1 + ((aw_w > w_w) ? aw_w : w_w);
    last = hs + 2 + b_w;
    check("wr_accept_ready", req_ready, 1);
    req_write = 1'b1; req_read = hold_read;
    req_addr = a; req_wdata = d; req_wstrb = s;
    @(posedge clk);
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req_write = 1'b0;
        if (!hold_read) begin
          req_addr = $urandom; req_wdata = $urandom; req_wstrb = 4'($urandom);
        end
      end
      exp = {c == last, c <= 1 + aw_w, c <= 1 + w_w, (c > hs) && (c < last),
             1'b0, 1'b0, c == last};
      check("wr_ctl", ctl(), exp);
      if (c <= 1 + aw_w) check("wr_awaddr", awaddr, a);
      if (c <= 1 + w_w)  check("wr_wdata_strb", {wstrb, wdata}, {s, d});
      if (c == last) begin
        check("wr_err", resp_err, br[1]);
        check("wr_rdata_hold", resp_rdata, last_rdata);
      end
      awready = (c == 1 + aw_w);
      wready  = (c == 1 + w_w);
      bvalid  = (c == hs + 1 + b_w);
      bresp   = bvalid ? br : 2'($urandom);
    end
  endtask

  // Read: AR accepted in cycle 1+ar_w, R delivered r_w cycles later.
  task automatic do_read(input logic [31:0] a, input int ar_w, input int r_w,
                         input logic [31:0] rd, input logic [1:0] rr);
    int         arh;
    int         last;
    logic [6:0] exp;
    arh  = 1 + ar_w;
    last = arh + 2 + r_w;
    check("rd_accept_ready", req_ready, 1);
    req_write = 1'b0; req_read = 1'b1; req_addr = a;
    @(posedge clk);
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req_read = 1'b0; req_addr = $urandom;
        check("rd_rdata_hold", resp_rdata, last_rdata);
      end
      exp = {c == last, 1'b0, 1'b0, 1'b0, c <= arh, (c > arh) && (c < last), c == last};
      check("rd_ctl", ctl(), exp);
      if (c <= arh) check("rd_araddr", araddr, a);
      if (c == last) begin
        check("rd_resp", {resp_err, resp_rdata}, {rr[1], rd});
        last_rdata = rd;
      end
      arready = (c == arh);
      rvalid  = (c == last - 1);
      rdata   = rvalid ? rd : $urandom;
      rresp   = rvalid ? rr : 2'($urandom);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    req_write = 1'b0; req_read = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    clear_slave();
    last_rdata = '0;
    #12;
    check("rst_ctl", ctl(), 7'b1000000);
    check("rst_addr", {awaddr, araddr}, 64'd0);
    check("rst_wdata", {wstrb, wdata}, 64'd0);
    check("rst_resp", {resp_err, resp_rdata}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("idle_after_rst", ctl(), 7'b1000000);

    // zero-wait write
    do_write(32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 2'b00, 1'b0);
    @(negedge clk);
    check("idle_gap", ctl(), 7'b1000000);

    // skewed write: W immediate, AW three wait cycles
    do_write(32'h2000_0010, 32'hCAFE_F00D, 4'h3, 3, 0, 0, 2'b00, 1'b0);
    // the opposite skew plus B wait
    do_write(32'h2000_0020, 32'h0BAD_CAFE, 4'hC, 0, 2, 2, 2'b00, 1'b0);

    // read with R wait
    do_read(32'h3000_0000, 0, 5, 32'h1234_5678, 2'b00);

    // write and read requested together: write first, read back-to-back
    do_write(32'h4000_0000, 32'h5555_AAAA, 4'h5, 1, 1, 1, 2'b00, 1'b1);
    do_read(32'h4000_0008, 1, 0, 32'h8765_4321, 2'b00);

    // error responses
    do_write(32'h5000_0000, 32'h1111_2222, 4'hF, 0, 0, 0, 2'b10, 1'b0);
    do_read(32'h5000_0004, 0, 0, 32'hA5A5_5A5A, 2'b00);
    do_read(32'h5000_0008, 2, 1, 32'h0F0F_F0F0, 2'b11);

    // reset while AW/W pending
    check("abort_ready", req_ready, 1);
    req_write = 1'b1; req_addr = 32'h6000_0000; req_wdata = 32'h7777_7777; req_wstrb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_write = 1'b0;
    check("abort_pending", {awvalid, wvalid}, 2'b11);
    awready = 1'b0; wready = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("abort_async_ctl", ctl(), 7'b1000000);
    check("abort_async_addr", {awaddr, wdata}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("abort_hold_ctl", ctl(), 7'b1000000);
    rst = 1'b1;
    last_rdata = '0;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_resp", ctl(), 7'b1000000);
    end
    do_read(32'h6000_0040, 0, 1, 32'hFEED_FACE, 2'b00);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      int kind;
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        do_write($urandom, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), 2'($urandom), 1'b0);
      end else if (kind == 1) begin
        do_read($urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 2'($urandom));
      end else begin
        do_write($urandom, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), 2'($urandom), 1'b1);
        do_read($urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 2'($urandom));
      end
      clear_slave();
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        check("rand_idle_gap", ctl(), 7'b1000000);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
